decomp_stream_fetch: RTL and testbench

Parametrised successor to the buffered decompressor top. It fetches compressed program words from the instruction memory and expands each token into one or more instructions from a writable token table. The expanded instructions go into a prefetch FIFO, and the CPU drains that FIFO over a valid/ready handshake. A redirect input lets the CPU restart the stream at any compressed address.

---
 rtl/decomp_stream_fetch_if.sv | 32 +++
 rtl/decomp_stream_fetch.sv | 150 +++++++++++++++
 tb/tb_decomp_stream_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/decomp_stream_fetch_if.sv
// Fetch/expand bus: imem read port, token-table write port,
// redirect and the decompressed-instruction valid/ready stream.
interface decomp_stream_fetch_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 7,
    parameter int unsigned FC_W  = 3
);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             tok_we;
    logic [IDX_W-1:0] tok_waddr;
    logic [WIDTH-1:0] tok_wdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic [FC_W-1:0]  fifo_count;

    modport slave (
        input  redirect, redirect_pc, imem_rdata,
        input  tok_we, tok_waddr, tok_wdata, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc, fifo_count
    );

    modport master (
        output redirect, redirect_pc, imem_rdata,
        output tok_we, tok_waddr, tok_wdata, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc, fifo_count
    );
endinterface

// File: rtl/decomp_stream_fetch.sv
// Compressed-stream fetch: expands token runs from a writable table
// into a prefetch FIFO drained by the CPU over valid/ready.
module decomp_stream_fetch #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [WIDTH-1:0] PCADD = 32'b100,
    parameter int unsigned ENC_LEN    = 4,
    parameter logic [ENC_LEN-1:0] OPCODE = 4'b1111,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    decomp_stream_fetch_if.slave bus
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned TBL = 1 << IDX_W;

    typedef enum logic {
        S_FETCH,
        S_EXPAND
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] tbl_q [TBL];

    logic [WIDTH-1:0] fdat_q [FIFO_DEPTH];
    logic [WIDTH-1:0] fpc_q  [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] word;
    logic             is_comp;
    logic [CNT_W-1:0] run;
    logic [IDX_W-1:0] idx;
    logic             push_ok;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    assign word    = bus.imem_rdata;
    assign is_comp = (word[WIDTH-1 -: ENC_LEN] == OPCODE);
    assign run     = word[WIDTH-ENC_LEN-1 -: CNT_W];
    assign idx     = word[IDX_W-1:0];
    assign push_ok = (cnt_q < CW'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        push      = 1'b0;
        push_data = word;
        pop       = (cnt_q != '0) && bus.instr_ready;
        unique case (state_q)
            S_FETCH: begin
                if (push_ok) begin
                    push      = 1'b1;
                    push_data = is_comp ? tbl_q[idx] : word;
                    if (is_comp && (run != '0)) begin
                        ptr_d   = idx + IDX_W'(1);
                        rem_d   = run;
                        state_d = S_EXPAND;
                    end else begin
                        pc_d = pc_q + PCADD;
                    end
                end
            end
            S_EXPAND: begin
                if (push_ok) begin
                    push      = 1'b1;
                    push_data = tbl_q[ptr_q];
                    ptr_d     = ptr_q + IDX_W'(1);
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        pc_d    = pc_q + PCADD;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
        // Redirect discards any in-flight run and the whole FIFO.
        if (bus.redirect) begin
            state_d = S_FETCH;
            pc_d    = bus.redirect_pc;
            rem_d   = '0;
            push    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (bus.redirect) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fdat_q[wptr_q] <= push_data;
            fpc_q[wptr_q]  <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.tok_we) tbl_q[bus.tok_waddr] <= bus.tok_wdata;
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (cnt_q != '0);
    assign bus.instr       = fdat_q[rptr_q];
    assign bus.instr_pc    = fpc_q[rptr_q];
    assign bus.fifo_count  = cnt_q;
endmodule

// File: tb/tb_decomp_stream_fetch.sv
// Directed bench for decomp_stream_fetch: pass-through, tokens,
// run wrap, backpressure, redirect flush and table write collision.
module tb_decomp_stream_fetch;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decomp_stream_fetch_if #(.WIDTH(32), .IDX_W(7), .FC_W(3)) bus ();

    decomp_stream_fetch #(
        .WIDTH(32), .PCADD(32'd4), .ENC_LEN(4), .OPCODE(4'hF),
        .CNT_W(2), .IDX_W(7), .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] mem [0:31];
    assign bus.imem_rdata = mem[bus.imem_addr[6:2]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] ins,
                        input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_instr"}, bus.instr, ins);
        chk({tag, "_pc"}, bus.instr_pc, pc);
    endtask

    function automatic logic [31:0] pt(input int i);
        return 32'h00A0_0000 | (32'(i) << 2);
    endfunction

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.tok_we      = 1'b0;
        bus.tok_waddr   = '0;
        bus.tok_wdata   = '0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = pt(i);
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        reset  = 1'b1;

        // reset then pass-through
        step();
        step();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        reset = 1'b0;
        chk("pt_addr0", bus.imem_addr, 32'd0);
        step();
        head("pt0", 32'h0000_0013, 32'd0);
        chk("pt_addr4", bus.imem_addr, 32'd4);
        step();
        head("pt1", 32'h0010_0093, 32'd4);
        chk("pt_addr8", bus.imem_addr, 32'd8);

        // single token, count field 0
        mem[0]          = 32'hF000_0005;
        bus.tok_we      = 1'b1;
        bus.tok_waddr   = 7'd5;
        bus.tok_wdata   = 32'hDEAD_BEEF;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd0;
        step();
        bus.tok_we   = 1'b0;
        bus.redirect = 1'b0;
        chk("tok_flush_cnt", 32'(bus.fifo_count), 32'd0);
        chk("tok_flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("tok_addr0", bus.imem_addr, 32'd0);
        step();
        head("tok", 32'hDEAD_BEEF, 32'd0);
        chk("tok_addr4", bus.imem_addr, 32'd4);

        // run of 3 with index wrap 127 -> 0 -> 1
        mem[0]          = 32'hF800_007F;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd0;
        bus.tok_we      = 1'b1;
        bus.tok_waddr   = 7'd127;
        bus.tok_wdata   = 32'hAAAA_0001;
        step();
        bus.tok_waddr = 7'd0;
        bus.tok_wdata = 32'hBBBB_0002;
        step();
        bus.tok_waddr = 7'd1;
        bus.tok_wdata = 32'hCCCC_0003;
        step();
        bus.tok_we   = 1'b0;
        bus.redirect = 1'b0;
        chk("run_addr_t0", bus.imem_addr, 32'd0);
        step();
        head("run_a", 32'hAAAA_0001, 32'd0);
        chk("run_addr_t1", bus.imem_addr, 32'd0);
        step();
        head("run_b", 32'hBBBB_0002, 32'd0);
        chk("run_addr_t2", bus.imem_addr, 32'd0);
        step();
        head("run_c", 32'hCCCC_0003, 32'd0);
        chk("run_addr_t3", bus.imem_addr, 32'd4);
        chk("run_cnt", 32'(bus.fifo_count), 32'd1);

        // backpressure at 0x40
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        chk("bp_cnt0", 32'(bus.fifo_count), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("bp_cnt%0d", k), 32'(bus.fifo_count), 32'(k));
            chk($sformatf("bp_addr%0d", k), bus.imem_addr, 32'h40 + 32'(4 * k));
        end
        step();
        chk("bp_full_cnt", 32'(bus.fifo_count), 32'd4);
        chk("bp_full_addr", bus.imem_addr, 32'h50);
        head("bp_full_head", pt(16), 32'h40);
        bus.instr_ready = 1'b1;
        step();
        chk("bp_pop_cnt", 32'(bus.fifo_count), 32'd3);
        chk("bp_pop_addr", bus.imem_addr, 32'h50);
        head("bp_h1", pt(17), 32'h44);
        for (int k = 2; k <= 5; k++) begin
            step();
            head($sformatf("bp_h%0d", k), pt(16 + k), 32'h40 + 32'(4 * k));
            chk($sformatf("bp_c%0d", k), 32'(bus.fifo_count), 32'd3);
        end

        // redirect in the middle of a count-3 run
        bus.instr_ready = 1'b0;
        mem[0]          = pt(0);
        mem[1]          = 32'hFC00_000A;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd0;
        bus.tok_we      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.tok_waddr = 7'(10 + k);
            bus.tok_wdata = 32'h7700_0000 + 32'(k);
            step();
        end
        bus.tok_we   = 1'b0;
        bus.redirect = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("rd_full_cnt", 32'(bus.fifo_count), 32'd4);
        chk("rd_full_addr", bus.imem_addr, 32'd4);
        head("rd_full_head", pt(0), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        chk("rd_flush_cnt", 32'(bus.fifo_count), 32'd0);
        chk("rd_flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("rd_addr", bus.imem_addr, 32'h40);
        step();
        head("rd_h0", pt(16), 32'h40);
        step();
        head("rd_h1", pt(17), 32'h44);

        // table write colliding with token read
        mem[0]          = 32'hF000_0003;
        mem[1]          = 32'hF000_0003;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd0;
        bus.tok_we      = 1'b1;
        bus.tok_waddr   = 7'd3;
        bus.tok_wdata   = 32'h0DD0_0003;
        step();
        bus.redirect  = 1'b0;
        bus.tok_wdata = 32'h0E0E_0003;
        chk("col_addr", bus.imem_addr, 32'd0);
        step();
        bus.tok_we = 1'b0;
        head("col_old", 32'h0DD0_0003, 32'd0);
        step();
        head("col_new", 32'h0E0E_0003, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
